// File: rtl/friscv_rd_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------------------+
// | friscv_rd_wb_arbiter: per-unit Rd write FIFOs, round-robin onto the register file.   |
// | Optional macro FRISCV_WB_BYPASS_EN: 1-cycle path when all FIFOs are empty. Rev 1.0   |
// +--------------------------------------------------------------------------------------+
module friscv_rd_wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int NB_UNIT    = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int NB_INT_REG = 32
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      srst,
  input  logic [NB_UNIT-1:0]        unit_rd_wr,
  input  logic [NB_UNIT*5-1:0]      unit_rd_addr,
  input  logic [NB_UNIT*XLEN-1:0]   unit_rd_val,
  input  logic [NB_UNIT*XLEN/8-1:0] unit_rd_strb,
  output logic                      rd_wr,
  output logic [4:0]                rd_addr,
  output logic [XLEN-1:0]           rd_val,
  output logic [XLEN/8-1:0]         rd_strb,
  output logic [NB_INT_REG-1:0]     wb_regs_sts,
  output logic                      wb_pending,
  output logic [NB_UNIT-1:0]        wb_overflow
);

  localparam int SW = XLEN / 8;
  localparam int EW = 5 + SW + XLEN;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int UW = (NB_UNIT > 1) ? $clog2(NB_UNIT) : 1;
  localparam int CW = $clog2(NB_UNIT * FIFO_DEPTH + 2);

  logic [EW-1:0]         w_in_ent [NB_UNIT];
  logic [EW-1:0]         w_head   [NB_UNIT];
  logic [NB_UNIT-1:0]    w_in_vld;
  logic [NB_UNIT-1:0]    w_nempty;
  logic [NB_UNIT-1:0]    w_full;
  logic [NB_UNIT-1:0]    w_push;
  logic [NB_UNIT-1:0]    w_pop;
  logic [NB_UNIT-1:0]    w_drop;
  logic [NB_UNIT-1:0]    w_acc;
  logic [NB_UNIT-1:0]    w_req;
  logic                  w_byp;
  logic                  w_grant;
  logic [UW-1:0]         w_gnt_idx;
  logic [UW:0]           w_idx;
  logic [EW-1:0]         w_gnt_ent;
  logic [CW-1:0]         w_cnt_nxt [NB_INT_REG];

  logic [UW-1:0]         r_rr_ptr;
  logic [NB_UNIT-1:0]    r_ovf;
  logic [CW-1:0]         r_cnt [NB_INT_REG];
  logic [NB_INT_REG-1:0] r_sts;

  genvar gu;
  for (gu = 0; gu < NB_UNIT; gu++) begin : g_unit
    logic [EW-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_level;

    assign w_in_ent[gu] = {unit_rd_addr[gu*5 +: 5], unit_rd_strb[gu*SW +: SW],
                           unit_rd_val[gu*XLEN +: XLEN]};
    assign w_in_vld[gu] = unit_rd_wr[gu] && (unit_rd_addr[gu*5 +: 5] != 5'd0);
    assign w_nempty[gu] = (r_level != '0);
    assign w_full[gu]   = (r_level == (AW+1)'(FIFO_DEPTH));
    assign w_head[gu]   = r_mem[r_rptr];

    always_ff @(posedge aclk) begin
      if (w_push[gu]) r_mem[r_wptr] <= w_in_ent[gu];
    end

    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_level <= '0;
      end else if (srst) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_level <= '0;
      end else begin
        if (w_push[gu]) r_wptr <= r_wptr + AW'(1);
        if (w_pop[gu])  r_rptr <= r_rptr + AW'(1);
        r_level <= r_level + (AW+1)'(w_push[gu]) - (AW+1)'(w_pop[gu]);
      end
    end
  end

  // Round-robin grant; in bypass mode the requesters are the incoming strobes themselves
  always_comb begin
    w_byp = 1'b0;
`ifdef FRISCV_WB_BYPASS_EN
    w_byp = (w_nempty == '0) && (w_in_vld != '0);
`endif
    w_req     = w_byp ? w_in_vld : w_nempty;
    w_grant   = 1'b0;
    w_gnt_idx = '0;
    w_idx     = '0;
    for (int k = 0; k < NB_UNIT; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (UW+1)'(k);
      if (w_idx >= (UW+1)'(NB_UNIT)) w_idx = w_idx - (UW+1)'(NB_UNIT);
      if (!w_grant && w_req[w_idx[UW-1:0]]) begin
        w_grant   = 1'b1;
        w_gnt_idx = w_idx[UW-1:0];
      end
    end
    w_gnt_ent = w_byp ? w_in_ent[w_gnt_idx] : w_head[w_gnt_idx];
    w_pop     = '0;
    if (w_grant && !w_byp) w_pop[w_gnt_idx] = 1'b1;
  end

  always_comb begin
    w_push = '0;
    w_drop = '0;
    w_acc  = '0;
    for (int i = 0; i < NB_UNIT; i++) begin
      if (w_in_vld[i] && !(w_byp && (w_gnt_idx == UW'(i)))) begin
        w_push[i] = !w_full[i] || w_pop[i];
        w_drop[i] = w_full[i] && !w_pop[i];
      end
      w_acc[i] = w_in_vld[i] && !w_drop[i];
    end
  end

  // A pending write ends when the rd_wr cycle carrying it completes
  always_comb begin
    for (int r = 0; r < NB_INT_REG; r++) begin
      w_cnt_nxt[r] = r_cnt[r];
      for (int u = 0; u < NB_UNIT; u++) begin
        if (w_acc[u] && (w_in_ent[u][EW-1 -: 5] == 5'(r)))
          w_cnt_nxt[r] = w_cnt_nxt[r] + CW'(1);
      end
      if (rd_wr && (rd_addr == 5'(r)))
        w_cnt_nxt[r] = w_cnt_nxt[r] - CW'(1);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_wr    <= 1'b0;
      rd_addr  <= '0;
      rd_val   <= '0;
      rd_strb  <= '0;
      r_rr_ptr <= '0;
      r_ovf    <= '0;
      r_sts    <= '1;
      for (int r = 0; r < NB_INT_REG; r++) r_cnt[r] <= '0;
    end else if (srst) begin
      rd_wr    <= 1'b0;
      rd_addr  <= '0;
      rd_val   <= '0;
      rd_strb  <= '0;
      r_rr_ptr <= '0;
      r_ovf    <= '0;
      r_sts    <= '1;
      for (int r = 0; r < NB_INT_REG; r++) r_cnt[r] <= '0;
    end else begin
      rd_wr <= w_grant;
      if (w_grant) begin
        {rd_addr, rd_strb, rd_val} <= w_gnt_ent;
        r_rr_ptr <= (w_gnt_idx == UW'(NB_UNIT-1)) ? '0 : w_gnt_idx + UW'(1);
      end
      r_ovf <= r_ovf | w_drop;
      for (int r = 0; r < NB_INT_REG; r++) begin
        r_cnt[r] <= w_cnt_nxt[r];
        r_sts[r] <= (w_cnt_nxt[r] == '0);
      end
    end
  end

  assign wb_regs_sts = r_sts;
  assign wb_overflow = r_ovf;
  assign wb_pending  = (w_nempty != '0) || rd_wr;

endmodule
`default_nettype wire

// File: tb/tb_friscv_rd_wb_arbiter.sv
`default_nettype none
// Bench for friscv_rd_wb_arbiter: directed and random writes, queue-based reference model,
// expected register-file writes scoreboarded and popped by an independent monitor.
module tb_friscv_rd_wb_arbiter;
  localparam int XLEN = 32, NB_UNIT = 3, FIFO_DEPTH = 4, NB_INT_REG = 32, SW = XLEN / 8;

  typedef struct packed {
    logic [4:0]      addr;
    logic [XLEN-1:0] val;
    logic [SW-1:0]   strb;
  } ent_t;

  logic aclk = 1'b0, aresetn = 1'b0, srst = 1'b0;
  logic [NB_UNIT-1:0]        unit_rd_wr;
  logic [NB_UNIT*5-1:0]      unit_rd_addr;
  logic [NB_UNIT*XLEN-1:0]   unit_rd_val;
  logic [NB_UNIT*SW-1:0]     unit_rd_strb;
  logic                      rd_wr;
  logic [4:0]                rd_addr;
  logic [XLEN-1:0]           rd_val;
  logic [SW-1:0]             rd_strb;
  logic [NB_INT_REG-1:0]     wb_regs_sts;
  logic                      wb_pending;
  logic [NB_UNIT-1:0]        wb_overflow;

  logic [NB_UNIT-1:0] in_wr;
  ent_t               in_e [NB_UNIT];

  for (genvar g = 0; g < NB_UNIT; g++) begin : g_pack
    assign unit_rd_wr[g]             = in_wr[g];
    assign unit_rd_addr[g*5 +: 5]    = in_e[g].addr;
    assign unit_rd_val[g*XLEN +: XLEN] = in_e[g].val;
    assign unit_rd_strb[g*SW +: SW]  = in_e[g].strb;
  end

  friscv_rd_wb_arbiter #(
    .XLEN(XLEN), .NB_UNIT(NB_UNIT), .FIFO_DEPTH(FIFO_DEPTH), .NB_INT_REG(NB_INT_REG)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .unit_rd_wr(unit_rd_wr), .unit_rd_addr(unit_rd_addr),
    .unit_rd_val(unit_rd_val), .unit_rd_strb(unit_rd_strb),
    .rd_wr(rd_wr), .rd_addr(rd_addr), .rd_val(rd_val), .rd_strb(rd_strb),
    .wb_regs_sts(wb_regs_sts), .wb_pending(wb_pending), .wb_overflow(wb_overflow)
  );

  always #5 aclk = ~aclk;

  int n_tests = 0, n_fail = 0;
  bit mon_en = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: state predicted for just after the next rising edge
  ent_t                  mq [NB_UNIT][$];
  ent_t                  exp_q [$];
  int                    m_cnt [NB_INT_REG];
  int                    m_ptr;
  bit                    m_rd_wr;
  logic [4:0]            m_out_addr;
  logic [NB_UNIT-1:0]    m_ovf;
  logic [NB_INT_REG-1:0] m_sts;
  bit                    m_pending;

  function automatic void model_reset();
    for (int u = 0; u < NB_UNIT; u++) mq[u].delete();
    exp_q.delete();
    for (int r = 0; r < NB_INT_REG; r++) m_cnt[r] = 0;
    m_ptr = 0; m_rd_wr = 0; m_out_addr = '0; m_ovf = '0; m_sts = '1; m_pending = 0;
  endfunction

  function automatic void model_step();
    bit byp;
    bit any_q;
    int g;
    bit [NB_UNIT-1:0] vld;
    if (!aresetn || srst) begin
      model_reset();
      return;
    end
    if (m_rd_wr) m_cnt[m_out_addr]--;
    for (int u = 0; u < NB_UNIT; u++) vld[u] = in_wr[u] && (in_e[u].addr != 5'd0);
    any_q = 0;
    for (int u = 0; u < NB_UNIT; u++) if (mq[u].size() > 0) any_q = 1;
    byp = 0;
`ifdef FRISCV_WB_BYPASS_EN
    byp = !any_q && (vld != 0);
`endif
    g = -1;
    for (int k = 0; k < NB_UNIT; k++) begin
      int u;
      u = (m_ptr + k) % NB_UNIT;
      if (g < 0 && (byp ? vld[u] : (mq[u].size() > 0))) g = u;
    end
    m_rd_wr = (g >= 0);
    if (g >= 0) begin
      ent_t e;
      if (byp) e = in_e[g];
      else     e = mq[g].pop_front();
      exp_q.push_back(e);
      m_out_addr = e.addr;
      m_ptr = (g + 1) % NB_UNIT;
    end
    for (int u = 0; u < NB_UNIT; u++) begin
      if (vld[u]) begin
        if (byp && u == g) m_cnt[in_e[u].addr]++;
        else if (mq[u].size() < FIFO_DEPTH) begin
          mq[u].push_back(in_e[u]);
          m_cnt[in_e[u].addr]++;
        end else m_ovf[u] = 1'b1;
      end
    end
    any_q = 0;
    for (int u = 0; u < NB_UNIT; u++) if (mq[u].size() > 0) any_q = 1;
    m_pending = any_q || m_rd_wr;
    for (int r = 0; r < NB_INT_REG; r++) m_sts[r] = (m_cnt[r] == 0);
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a write
  always @(negedge aclk) begin
    if (mon_en) begin
      chk("rd_wr_timing", rd_wr, m_rd_wr);
      if (rd_wr) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_write: got addr %0d val %0h expected no write", rd_addr, rd_val);
        end else begin
          ent_t e;
          e = exp_q.pop_front();
          chk("rd_addr", rd_addr, e.addr);
          chk("rd_val", rd_val, e.val);
          chk("rd_strb", rd_strb, e.strb);
        end
      end
      chk("wb_regs_sts", wb_regs_sts, m_sts);
      chk("wb_pending", wb_pending, m_pending);
      chk("wb_overflow", wb_overflow, m_ovf);
    end
  end

  task automatic idle_inputs();
    in_wr = '0;
    for (int u = 0; u < NB_UNIT; u++) in_e[u] = '0;
  endtask

  task automatic wr(int u, int addr, logic [XLEN-1:0] val, logic [SW-1:0] strb);
    in_wr[u]     = 1'b1;
    in_e[u].addr = 5'(addr);
    in_e[u].val  = val;
    in_e[u].strb = strb;
  endtask

  task automatic step();
    model_step();
    @(negedge aclk);
    #1;
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_rd_wr"}, rd_wr, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_rd_val"}, rd_val, 0);
    chk({tag, "_rd_strb"}, rd_strb, 0);
    chk({tag, "_sts"}, wb_regs_sts, {NB_INT_REG{1'b1}});
    chk({tag, "_pending"}, wb_pending, 0);
    chk({tag, "_overflow"}, wb_overflow, 0);
  endtask

  task automatic burst(int a0, int a1, int a2);
    wr(0, a0, XLEN'($urandom), SW'($urandom));
    wr(1, a1, XLEN'($urandom), SW'($urandom));
    wr(2, a2, XLEN'($urandom), SW'($urandom));
  endtask

  initial begin
    idle_inputs();
    model_reset();
    repeat (3) @(negedge aclk);
    #1;
    chk_reset_outputs("init");
    aresetn = 1'b1;
    mon_en  = 1'b1;
    step();

    // Single ALU write x5
    wr(0, 5, 32'h1234, 4'hF); step(); idle_inputs();
    chk("x5_pending_sts", wb_regs_sts[5], 0);
    repeat (5) step();

    // Simultaneous bursts, round-robin restarts at unit 0
    burst(1, 2, 3); step(); idle_inputs(); repeat (5) step();
    burst(4, 5, 6); step(); idle_inputs(); repeat (5) step();

    // Writes to x0 are ignored
    wr(1, 0, 32'hFFFF, 4'hF); step(); idle_inputs(); repeat (3) step();

    // Two writes in flight to x7
    wr(0, 7, 32'hA5A5, 4'h3); step(); idle_inputs();
    wr(2, 7, 32'h5A5A, 4'hC); step(); idle_inputs();
    chk("x7_two_pending", wb_regs_sts[7], 0);
    repeat (6) step();

    // Saturating load: every unit every cycle
    repeat (8) begin
      burst($urandom_range(1, 31), $urandom_range(1, 31), $urandom_range(1, 31));
      step();
    end
    idle_inputs();
    repeat (25) step();
    chk("stress_overflow", wb_overflow, {NB_UNIT{1'b1}});
    chk("stress_drained_sts", wb_regs_sts, {NB_INT_REG{1'b1}});

    // Asynchronous reset with writes queued and one on the port
    burst(8, 9, 10); step(); burst(11, 12, 13); step(); idle_inputs();
    aresetn = 1'b0;
    model_reset();
    #1;
    chk_reset_outputs("arst");
    step(); step();
    aresetn = 1'b1;
    repeat (6) step();

    // Same scenario with the synchronous reset
    burst(8, 9, 10); step(); burst(11, 12, 13); step(); idle_inputs();
    srst = 1'b1; step(); srst = 1'b0;
    chk_reset_outputs("srst");
    repeat (6) step();

    // Random traffic
    repeat (400) begin
      for (int u = 0; u < NB_UNIT; u++) begin
        in_wr[u]     = ($urandom_range(0, 99) < 35);
        in_e[u].addr = 5'($urandom_range(0, 31));
        in_e[u].val  = XLEN'($urandom);
        in_e[u].strb = SW'($urandom);
      end
      step();
    end
    idle_inputs();
    repeat (30) step();
    chk("final_sts", wb_regs_sts, {NB_INT_REG{1'b1}});
    chk("final_pending", wb_pending, 0);
    chk("final_scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/friscv_rd_wb_arbiter.md
Name: friscv_rd_wb_arbiter

Overview:
- Write-back stage directly downstream of the processing unit.
- Collects the per-unit Rd write requests (ALU, memfy, M extension) and serialises them onto the single ISA register-file write port.
- Each unit has its own FIFO; a round-robin arbiter selects between them.
- Exports a per-register pending-write status, so the issue logic can block hazards on registers still in flight.

Parameters:
- XLEN, 32, register width
- NB_UNIT, 3, number of Rd write sources
- FIFO_DEPTH, 4, entries per unit FIFO (power of 2, ≥2)
- NB_INT_REG, 32, number of integer registers (16 for RV32E)

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- srst  in  1  synchronous reset, active high
- unit_rd_wr  in  NB_UNIT  per-unit write strobe, fire-and-forget, no ready
- unit_rd_addr  in  NB_UNIT*5  per-unit destination register
- unit_rd_val  in  NB_UNIT*XLEN  per-unit write data
- unit_rd_strb  in  NB_UNIT*XLEN/8  per-unit byte strobes
- rd_wr  out  1  register-file write strobe
- rd_addr  out  5  register-file destination
- rd_val  out  XLEN  register-file data
- rd_strb  out  XLEN/8  register-file byte strobes
- wb_regs_sts  out  NB_INT_REG  bit i = 1 when no write to xi is pending
- wb_pending  out  1  any FIFO non-empty or rd_wr asserted
- wb_overflow  out  NB_UNIT  sticky per-unit drop flag

Behaviour:
- Reset (aresetn low, or srst at an edge):
  - rd_wr, rd_addr, rd_val, rd_strb = 0
  - wb_regs_sts = all ones; wb_pending = 0; wb_overflow = 0
  - FIFOs emptied, all pending counters = 0, RR pointer = 0
  - Reset mid-operation discards all buffered writes; nothing is written after reset.
- Input:
  - unit_rd_wr[i] sampled at edge E0 pushes {addr,val,strb} into FIFO i.
  - Writes with addr = 0 are discarded: no push, no counter change, no overflow.
- Full FIFO:
  - Push into a full FIFO with no pop at the same edge: the write is dropped and wb_overflow[i] is set, held until reset.
  - Push and pop at the same edge on a full FIFO: the push is accepted.
- Arbitration:
  - At each edge, if any FIFO is non-empty, the arbiter grants one unit, pops its head and loads the output register. rd_wr is high for exactly one cycle per entry.
  - Round-robin: search starts at (last grant + 1) mod NB_UNIT. After reset, unit 0 has highest priority.
  - The pointer advances only on a grant.
- Latency: 2 cycles from unit_rd_wr to rd_wr (push at E0, pop/load at E1, rd_wr visible after E1).
- Throughput: one write per cycle. Back-to-back grants produce continuous rd_wr with no bubble.
- Ordering:
  - Per unit: FIFO order is preserved.
  - Across units: no ordering guarantee; the issue stage prevents same-Rd conflicts via wb_regs_sts.
- Pending counters:
  - One per register, width $clog2(NB_UNIT*FIFO_DEPTH+2).
  - +1 on an accepted push to xi.
  - −1 at the edge that ends an rd_wr cycle with rd_addr = xi (the write has reached the register file).
  - Increment and decrement at the same edge on the same register: net unchanged.
  - wb_regs_sts[i] = (count[i] == 0), registered from the counters; bit 0 is always 1.
- Simultaneous pushes from all units in one cycle are all accepted if space exists.
- Strobes pass through unmodified.

Optional Feature:
- Macro: FRISCV_WB_BYPASS_EN.
- Enabled:
  - Condition: all FIFOs are empty at the edge and exactly the incoming strobes of one or more units are active.
  - The round-robin winner among the incoming units is loaded directly into the output register at E0 (latency 1).
  - The other incoming units are pushed into their FIFOs.
  - The counter still increments at E0 and decrements when the rd_wr cycle ends.
- Disabled: every write goes through its FIFO (latency 2).

Test Plan:
- Single ALU write x5=0x1234, strb 0xF.
  - rd_wr rises 2 cycles later (1 with FRISCV_WB_BYPASS_EN) with addr 5, val 0x1234.
  - wb_regs_sts[5] = 0 from the cycle after the push until the cycle after rd_wr.
- All 3 units write in the same cycle (x1, x2, x3) after reset.
  - Three consecutive rd_wr cycles in order x1, x2, x3.
  - Next simultaneous burst (x4, x5, x6) is served x4, x5, x6, because the RR pointer is at unit 0 again.
- Unit 1 writes x0 = 0xFFFF.
  - No rd_wr, wb_pending stays 0, wb_overflow stays 0.
- All units write every cycle for 8 cycles, FIFO_DEPTH = 4.
  - Drops occur and wb_overflow bits set and stay set.
  - Accepted writes all appear on rd_wr, and wb_regs_sts returns to all ones once drained.
- Unit 0 and unit 2 both write x7 in consecutive cycles.
  - Counter reaches 2; wb_regs_sts[7] stays 0 until the second rd_wr to x7 completes.
- Assert aresetn low with 3 entries queued.
  - All outputs 0 immediately, wb_regs_sts all ones.
  - No rd_wr after release.
  - Repeat the same scenario using srst with identical results.
